// File: rtl/demux_to_mux_2_pkg.sv
// Shared constants and helpers for the two-lane split/merge stream block.

package demux_to_mux_2_pkg;

   localparam int unsigned LANES = 2;

   // Width of a counter that must represent 0..max_out inclusive.
   function automatic int unsigned cnt_w(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/demux_to_mux_2_pipe_reg_1.sv
// One-entry valid/ready register slice: load wins, otherwise hold until the consumer takes it.

module demux_to_mux_2_pipe_reg_1
   import demux_to_mux_2_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/demux_to_mux_2.sv
// Alternates an input stream over two external lanes and re-merges the results in order,
// using matched 1-bit dispatch/merge pointers and an in-flight credit counter.

module demux_to_mux_2
   import demux_to_mux_2_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [LANES-1:0][WIDTH-1:0]  lane_req_data,
   output logic [LANES-1:0]             lane_req_valid,
   input  logic [LANES-1:0]             lane_req_ready,
   input  logic [LANES-1:0][WIDTH-1:0]  lane_rsp_data,
   input  logic [LANES-1:0]             lane_rsp_valid,
   output logic [LANES-1:0]             lane_rsp_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [cnt_w(MAX_OUT)-1:0]    inflight
);

   localparam int unsigned      CntW   = cnt_w(MAX_OUT);
   localparam logic [CntW-1:0]  MaxCnt = CntW'(MAX_OUT);
   localparam logic [CntW-1:0]  OneCnt = CntW'(1);

   logic             r_wr_sel;
   logic             r_rd_sel;
   logic [CntW-1:0]  r_inflight;

   logic             w_in_ready;
   logic             w_in_fire;
   logic [LANES-1:0] w_req_load;
   logic             w_out_free;
   logic             w_rsp_fire;
   logic [WIDTH-1:0] w_rsp_data;
   logic             w_out_fire;

   always_comb begin
      // Registered count only: a same-cycle output transfer does not free a slot.
      w_in_ready = (r_inflight < MaxCnt) &&
                   (!lane_req_valid[r_wr_sel] || lane_req_ready[r_wr_sel]);
      w_in_fire  = in_valid && w_in_ready;

      w_req_load             = '0;
      w_req_load[r_wr_sel]   = w_in_fire;

      w_out_free             = !out_valid || out_ready;
      lane_rsp_ready         = '0;
      lane_rsp_ready[r_rd_sel] = w_out_free;
      w_rsp_fire             = lane_rsp_valid[r_rd_sel] && w_out_free;
      w_rsp_data             = lane_rsp_data[r_rd_sel];

      w_out_fire             = out_valid && out_ready;
   end

   assign in_ready = w_in_ready;
   assign inflight = r_inflight;

   for (genvar l = 0; l < LANES; l++) begin : g_lane_req
      demux_to_mux_2_pipe_reg_1 #(
         .WIDTH (WIDTH)
      ) u_req_reg (
         .i_clock (clock),
         .i_reset (reset),
         .i_load  (w_req_load[l]),
         .i_data  (in_data),
         .i_ready (lane_req_ready[l]),
         .o_valid (lane_req_valid[l]),
         .o_data  (lane_req_data[l])
      );
   end

   demux_to_mux_2_pipe_reg_1 #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .i_clock (clock),
      .i_reset (reset),
      .i_load  (w_rsp_fire),
      .i_data  (w_rsp_data),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_data  (out_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_sel   <= 1'b0;
         r_rd_sel   <= 1'b0;
         r_inflight <= '0;
      end else begin
         if (w_in_fire) begin
            r_wr_sel <= ~r_wr_sel;
         end
         if (w_rsp_fire) begin
            r_rd_sel <= ~r_rd_sel;
         end
         if (w_in_fire && !w_out_fire) begin
            r_inflight <= r_inflight + OneCnt;
         end else if (!w_in_fire && w_out_fire) begin
            r_inflight <= r_inflight - OneCnt;
         end
      end
   end

endmodule

// File: tb/tb_demux_to_mux_2.sv
// Scoreboard bench: accepted inputs are queued as expected outputs, a negedge monitor pops/compares.

module tb_demux_to_mux_2;

   logic              clock = 1'b0;
   logic              reset;
   logic [31:0]       in_data;
   logic              in_valid;
   logic              in_ready;
   logic [1:0][31:0]  lane_req_data;
   logic [1:0]        lane_req_valid;
   logic [1:0]        lane_req_ready;
   logic [1:0][31:0]  lane_rsp_data;
   logic [1:0]        lane_rsp_valid;
   logic [1:0]        lane_rsp_ready;
   logic [31:0]       out_data;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        inflight;

   logic [1:0]        hold;
   int                lat0;
   int                lat1;

   int                checks = 0;
   int                passes = 0;

   logic [31:0]       sb[$];
   logic [31:0]       stim[$];

   typedef struct {
      logic [31:0] d;
      int          t;
   } ent_t;

   ent_t              lq0[$];
   ent_t              lq1[$];
   int                cyc = 0;

   assign lane_req_ready = ~hold;

   always #5 clock = ~clock;

   demux_to_mux_2 #(
      .WIDTH   (32),
      .MAX_OUT (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .lane_req_data  (lane_req_data),
      .lane_req_valid (lane_req_valid),
      .lane_req_ready (lane_req_ready),
      .lane_rsp_data  (lane_rsp_data),
      .lane_rsp_valid (lane_rsp_valid),
      .lane_rsp_ready (lane_rsp_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .inflight       (inflight)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Lane models: identity operator, unbounded queue, fixed latency in edges.
   initial begin : lane_model
      lane_rsp_valid = 2'b00;
      lane_rsp_data  = '0;
      forever begin
         @(posedge clock);
         if (reset) begin
            lq0.delete();
            lq1.delete();
            lane_rsp_valid <= 2'b00;
         end else begin
            if (lane_rsp_valid[0] && lane_rsp_ready[0]) void'(lq0.pop_front());
            if (lane_rsp_valid[1] && lane_rsp_ready[1]) void'(lq1.pop_front());
            if (lane_req_valid[0] && lane_req_ready[0])
               lq0.push_back('{d: lane_req_data[0], t: cyc + lat0});
            if (lane_req_valid[1] && lane_req_ready[1])
               lq1.push_back('{d: lane_req_data[1], t: cyc + lat1});
            if (lq0.size() > 0 && lq0[0].t <= cyc) begin
               lane_rsp_valid[0] <= 1'b1;
               lane_rsp_data[0]  <= lq0[0].d;
            end else begin
               lane_rsp_valid[0] <= 1'b0;
            end
            if (lq1.size() > 0 && lq1[0].t <= cyc) begin
               lane_rsp_valid[1] <= 1'b1;
               lane_rsp_data[1]  <= lq1[0].d;
            end else begin
               lane_rsp_valid[1] <= 1'b0;
            end
         end
         cyc++;
      end
   end

   // Monitor: output order, request routing (bench's own alternating pointer), credit sanity.
   initial begin : monitor
      logic        m_wr;
      logic        pend_v;
      logic        pend_l;
      logic [31:0] pend_d;
      logic [31:0] exp;
      m_wr   = 1'b0;
      pend_v = 1'b0;
      pend_l = 1'b0;
      pend_d = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete();
            m_wr   = 1'b0;
            pend_v = 1'b0;
         end else begin
            if (pend_v) begin
               chk("req_valid_lane", 32'(lane_req_valid[pend_l]), 32'd1);
               chk("req_data_lane", lane_req_data[pend_l], pend_d);
               pend_v = 1'b0;
            end
            if (out_valid && out_ready) begin
               chk("inflight_nonzero_on_out", 32'(inflight != 3'd0), 32'd1);
               if (sb.size() == 0) begin
                  checks++;
                  $display("FAIL spurious_output: got %h, expected no output", out_data);
               end else begin
                  exp = sb.pop_front();
                  chk("out_order", out_data, exp);
               end
            end
            if (in_valid && in_ready) begin
               sb.push_back(in_data);
               pend_v = 1'b1;
               pend_l = m_wr;
               pend_d = in_data;
               m_wr   = ~m_wr;
            end
         end
      end
   end

   // Entered and left at posedge+1; offers stim[] back-to-back.
   task automatic send_all();
      int w;
      while (stim.size() > 0) begin
         in_valid = 1'b1;
         in_data  = stim[0];
         w = 0;
         @(negedge clock);
         while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
         end
         if (!in_ready) begin
            chk("input_accept_timeout", 32'(in_ready), 32'd1);
            stim.delete();
         end else begin
            void'(stim.pop_front());
         end
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      hold      = 2'b00;
      lat0      = 1;
      lat1      = 1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_req_valid", 32'(lane_req_valid), 32'd0);
      chk("rst_req_data0", lane_req_data[0], 32'd0);
      chk("rst_req_data1", lane_req_data[1], 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      @(posedge clock);
      #1;

      // Ordered streaming.
      stim = '{32'h10, 32'h11, 32'h12, 32'h13};
      send_all();
      drain();

      // Skewed latency: lane 1 finishes first but must wait for lane 0.
      lat0 = 6;
      stim = '{32'hA, 32'hB};
      send_all();
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("skew_rsp_ready1", 32'(lane_rsp_ready[1]), 32'd0);
      chk("skew_rsp_ready0", 32'(lane_rsp_ready[0]), 32'd1);
      chk("skew_out_valid", 32'(out_valid), 32'd0);
      @(posedge clock);
      #1;
      drain();
      lat0 = 1;

      // Credit limit with output stalled.
      out_ready = 1'b0;
      stim = '{32'h20, 32'h21, 32'h22, 32'h23};
      send_all();
      @(negedge clock);
      chk("credit_inflight_full", 32'(inflight), 32'd4);
      in_valid = 1'b1;
      in_data  = 32'h24;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("credit_in_ready_low", 32'(in_ready), 32'd0);
      end
      chk("credit_inflight_hold", 32'(inflight), 32'd4);
      chk("credit_out_valid", 32'(out_valid), 32'd1);
      chk("credit_out_data", out_data, 32'h20);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      stim = '{32'h24, 32'h25};
      send_all();
      drain();

      // Simultaneous input and output transfer at inflight==2.
      out_ready = 1'b0;
      stim = '{32'h30, 32'h31};
      send_all();
      repeat (4) @(posedge clock);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h32;
      @(negedge clock);
      chk("simul_inflight_pre", 32'(inflight), 32'd2);
      chk("simul_in_ready", 32'(in_ready), 32'd1);
      chk("simul_out_valid", 32'(out_valid), 32'd1);
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      chk("simul_inflight_post", 32'(inflight), 32'd2);
      chk("simul_out_data_next", out_data, 32'h31);
      @(posedge clock);
      #1;
      drain();

      // Lane 0 request back-pressure; realign so the dispatch pointer sits on lane 0.
      stim = '{32'h33};
      send_all();
      drain();
      hold[0] = 1'b1;
      stim = '{32'h40, 32'h41};
      send_all();
      in_valid = 1'b1;
      in_data  = 32'h42;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      chk("bp_req_valid0", 32'(lane_req_valid[0]), 32'd1);
      chk("bp_req_data0", lane_req_data[0], 32'h40);
      chk("bp_req_valid1_free", 32'(lane_req_valid[1]), 32'd0);
      chk("bp_inflight", 32'(inflight), 32'd2);
      @(posedge clock);
      #1;
      hold[0] = 1'b0;
      stim = '{32'h42};
      send_all();
      drain();

      // Reset mid-operation with three in flight.
      out_ready = 1'b0;
      stim = '{32'h50, 32'h51, 32'h52};
      send_all();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_req_valid", 32'(lane_req_valid), 32'd0);
      chk("mid_rst_inflight", 32'(inflight), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      stim = '{32'h55};
      send_all();
      drain();

      chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/demux_to_mux_2.md
Name: demux_to_mux_2

Overview:
- Splits one valid/ready input stream across two external processing lanes in strict alternation (lane 0, lane 1, lane 0, ...), then re-merges the lane results into one output stream in the original order.
- Used to double the throughput of a slow or non-pipelined operator by instancing it twice behind one stream interface.
- Lanes may have arbitrary, differing latency. Ordering is guaranteed by matched dispatch and merge pointers.

Parameters:
- WIDTH, 32, data width of the input, lane and output payloads.
- MAX_OUT, 4, maximum transactions in flight (accepted at input, not yet emitted at output); >=2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input payload.
- in_valid  input  1  input payload valid.
- in_ready  output  1  block accepts input this cycle.
- lane_req_data  output  [1:0][WIDTH]  per-lane request payload.
- lane_req_valid  output  [1:0]  per-lane request valid.
- lane_req_ready  input  [1:0]  per-lane request ready.
- lane_rsp_data  input  [1:0][WIDTH]  per-lane result payload.
- lane_rsp_valid  input  [1:0]  per-lane result valid.
- lane_rsp_ready  output  [1:0]  per-lane result ready.
- out_data  output  WIDTH  merged result payload (registered).
- out_valid  output  1  merged result valid (registered).
- out_ready  input  1  downstream ready.
- inflight  output  $clog2(MAX_OUT+1)  current in-flight count.

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle. A valid, once asserted, holds its data stable until the transfer; this applies to all outputs.
- Reset (synchronous, active-high):
  - wr_sel=0, rd_sel=0, inflight=0.
  - lane_req_valid=2'b00, lane_req_data=0.
  - out_valid=0, out_data=0.
  - In-flight data is discarded; external lanes are reset by the same signal.
- Dispatch:
  - One request register per lane.
  - in_ready = (inflight < MAX_OUT) && (!lane_req_valid[wr_sel] || lane_req_ready[wr_sel]).
  - On input transfer: lane_req_data[wr_sel] <= in_data, lane_req_valid[wr_sel] <= 1, wr_sel toggles.
  - A lane's request valid clears on its request transfer unless reloaded the same cycle.
  - Latency: input accepted at cycle t -> lane_req_valid at t+1.
- Merge:
  - lane_rsp_ready[l] = (l == rd_sel) && (!out_valid || out_ready); the other lane's ready is 0.
  - On response transfer from rd_sel: out_data <= that lane's data, out_valid <= 1, rd_sel toggles.
  - out_valid clears on output transfer when no new response loads.
  - Latency: response accepted at cycle u -> out_valid at u+1. Full throughput, one beat per cycle, when lanes keep up.
- In-flight counter:
  - +1 on input transfer, -1 on output transfer; both in one cycle -> unchanged.
  - Never exceeds MAX_OUT and never underflows.
  - An output transfer with inflight==0 is impossible by construction; the bench asserts it never occurs.
- Ordering:
  - The Nth accepted input's result is the Nth output, regardless of relative lane latency.
  - A lane-1 result arriving before the lane-0 result is held off by lane_rsp_ready=0 until lane 0 completes.
- Boundaries:
  - inflight==MAX_OUT -> in_ready=0 even if the lane register is free.
  - A same-cycle output transfer does not free the slot for that cycle's input; in_ready uses the registered count.
  - Pointer wrap: wr_sel and rd_sel are 1-bit toggles; no other wrap state exists.
  - out_ready low indefinitely -> out_valid/out_data held, lanes back-pressured, input stalls at MAX_OUT.

Decomposition:
- Shared package: LANES=2 constant; width helper function cnt_w(MAX_OUT) = $clog2(MAX_OUT+1); stream struct typedef {data, valid} is optional.
- One natural sub-module: pipe_reg_1, a one-entry valid/ready register slice (load, hold, clear). Instanced twice for the lane request registers and once for the output register.

Test Plan:
- Ordered streaming: lanes ready, lane 0 latency 1, lane 1 latency 1; inputs 0x10,0x11,0x12,0x13 back-to-back -> requests alternate lane0=0x10,lane1=0x11,lane0=0x12,lane1=0x13; outputs 0x10..0x13 in order, one per cycle after fill.
- Skewed latency: lane 0 latency 6, lane 1 latency 1; inputs 0xA,0xB -> lane_rsp_ready[1]=0 until 0xA is emitted; out sequence 0xA then 0xB.
- Credit limit: MAX_OUT=4, out_ready=0, 6 inputs offered -> exactly 4 accepted, in_ready=0, inflight=4. Raise out_ready -> remaining 2 accepted, 6 outputs in order.
- Simultaneous in/out: inflight=2, input and output transfer in the same cycle -> inflight stays 2, wr_sel and rd_sel both toggle.
- Lane request back-pressure: lane_req_ready[0]=0 with lane 0 register full -> in_ready=0 while wr_sel=0; lane 1 request unaffected.
- Reset mid-operation: 3 in flight, assert reset for 1 cycle -> next cycle in_valid/out_valid/lane_req_valid=0, inflight=0, wr_sel=rd_sel=0; new input 0x55 routes to lane 0 and emerges as the first output.
